sr_excitation_driver: RTL and testbench



---
 rtl/ff_pkg.sv | 20 ++
 rtl/sr_excite_bit.sv | 28 ++
 rtl/sr_excitation_driver.sv | 90 +++++++++
 tb/tb_sr_excitation_driver.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// Shared definitions for the SR excitation driver: FSM encoding, per-bit
// excitation rule and counter widths.
package ff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;
  localparam int SETTLE_CNT_W = 4;

  // {S,R} that moves one SR flop from q to target; zero when already there.
  function automatic logic [1:0] sr_excite(input logic target, input logic q);
    return {target & ~q, ~target & q};
  endfunction

endpackage

// File: rtl/sr_excite_bit.sv
// One bit of registered S/R excitation, one-cycle latency from load.
// No backpressure; load takes priority over the synchronous clear.
module sr_excite_bit
  import ff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr,
  input  logic target,
  input  logic q,
  output logic s,
  output logic r
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s <= 1'b0;
      r <= 1'b0;
    end else if (load) begin
      {s, r} <= sr_excite(target, q);
    end else if (clr) begin
      s <= 1'b0;
      r <= 1'b0;
    end
  end

endmodule

// File: rtl/sr_excitation_driver.sv
// Closed-loop SR bank driver: one-cycle excitation, SETTLE idle cycles, compare.
// Latency SETTLE+3 per transaction; tgt_ready only in IDLE, so tgt_valid stalls while busy.
module sr_excitation_driver
  import ff_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     tgt,
  input  logic                 tgt_valid,
  output logic                 tgt_ready,
  output logic [WIDTH-1:0]     S,
  output logic [WIDTH-1:0]     R,
  input  logic [WIDTH-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_M1 = SETTLE_CNT_W'(SETTLE - 1);

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        tgt_q;
  logic [SETTLE_CNT_W-1:0] cnt;
  logic                    load;
  logic                    clr;
  logic                    mismatch;

  assign tgt_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mismatch  = (Q != tgt_q);
  // Excitation lives exactly one cycle: anything but a fresh load clears it.
  assign clr       = ~load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          load    = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE:   state_d = WAIT;
      WAIT:    if (cnt == '0) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q   <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= (state_q == CHECK);
      err  <= (state_q == CHECK) && mismatch;
      if (load) tgt_q <= tgt;
      if (state_q == DRIVE) cnt <= SETTLE_M1;
      else if (state_q == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (state_q == CHECK && mismatch && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_excite_bit u_bit (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .clr    (clr),
      .target (tgt[i]),
      .q      (Q[i]),
      .s      (S[i]),
      .r      (R[i])
    );
  end

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Directed bench: driver closed around four behavioural SR flops with an
// optional stuck-at-0 mask on their outputs.
module tb_sr_excitation_driver;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] tgt;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] S, R, Q;
  logic             busy, done, err;
  logic [7:0]       err_cnt;

  logic [WIDTH-1:0] fq = '0;
  logic [WIDTH-1:0] stuck = '0;

  int errors = 0;
  int checks = 0;

  sr_excitation_driver #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .tgt       (tgt),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .S         (S),
    .R         (R),
    .Q         (Q),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // SR flop bank model
  always @(posedge clk) fq <= (fq | S) & ~R;
  assign Q = fq & ~stuck;

  typedef struct {
    logic [3:0] stuck;
    logic [3:0] tgt;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] q;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input logic [3:0] t, input logic [3:0] es, input logic [3:0] er,
                         input logic [3:0] eq, input logic ee, input logic [7:0] ecnt,
                         input logic hold, input logic [3:0] nt);
    int  k;
    bit  seen;
    tgt       = t;
    tgt_valid = 1'b1;
    for (int i = 0; i < 20 && tgt_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("ready_before_accept", tgt_ready, 1);
    @(posedge clk); #1;
    if (hold) tgt = nt;
    else tgt_valid = 1'b0;
    check("S_drive", S, es);
    check("R_drive", R, er);
    check("busy_drive", busy, 1);
    check("ready_drive", tgt_ready, 0);
    seen = 1'b0;
    k    = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      k = i;
      check("sr_quiet", {S, R}, 0);
      if (done === 1'b1) seen = 1'b1;
      else check("ready_busy_wait", {tgt_ready, busy}, 2'b01);
    end
    check("done_latency", seen ? k : 99, SETTLE + 2);
    check("err", err, ee);
    check("err_cnt", err_cnt, ecnt);
    check("q_final", Q, eq);
    check("ready_at_done", tgt_ready, 1);
    check("busy_at_done", busy, 0);
    if (!hold) begin
      @(posedge clk); #1;
      check("done_drop", {done, err}, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000, 4'b1010, 1'b0, 8'd0};
    vecs[1] = '{4'b0000, 4'b0110, 4'b0100, 4'b1000, 4'b0110, 1'b0, 8'd0};
    vecs[2] = '{4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0110, 1'b0, 8'd0};
    vecs[3] = '{4'b0000, 4'b1111, 4'b1001, 4'b0000, 4'b1111, 1'b0, 8'd0};
    vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 8'd0};
    vecs[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 8'd1};

    rst       = 1'b1;
    tgt       = '0;
    tgt_valid = 1'b0;
    @(posedge clk); #1;
    tgt_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_sr", {S, R}, 0);
    check("rst_done_err", {done, err}, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_ready", tgt_ready, 1);
    check("rst_busy", busy, 0);
    tgt_valid = 1'b0;
    rst       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_quiet", {busy, done, S, R}, 0);
    end

    for (int v = 0; v < 6; v++) begin
      stuck = vecs[v].stuck;
      run_txn(vecs[v].tgt, vecs[v].s, vecs[v].r, vecs[v].q, vecs[v].err, vecs[v].cnt, 1'b0, 4'b0);
    end

    for (int n = 2; n <= 256; n++)
      run_txn(4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, (n > 255) ? 8'd255 : 8'(n), 1'b0, 4'b0);

    // Releasing the stuck output exposes the flop's real state
    stuck = '0;
    #1;
    check("q_release", Q, 4'b0001);

    tgt       = 4'b1110;
    tgt_valid = 1'b1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    check("abort_drive_S", S, 4'b1110);
    check("abort_drive_R", R, 4'b0001);
    rst = 1'b1;
    #1;
    check("abort_drive_sr", {S, R}, 0);
    check("abort_drive_state", {busy, tgt_ready}, 2'b01);
    check("abort_err_cnt", err_cnt, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_drive_no_done", done, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_drive_idle", {done, busy, Q}, {2'b00, 4'b0001});
    end

    tgt       = 4'b0011;
    tgt_valid = 1'b1;
    @(posedge clk); #1;
    tgt_valid = 1'b0;
    check("abort_wait_S", S, 4'b0010);
    @(posedge clk); #1;
    check("abort_wait_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_wait_sr", {S, R}, 0);
    check("abort_wait_ready", tgt_ready, 1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("abort_wait_no_done", done, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("abort_wait_idle", {done, busy, Q}, {2'b00, 4'b0011});
    end

    run_txn(4'b0101, 4'b0100, 4'b0010, 4'b0101, 1'b0, 8'd0, 1'b0, 4'b0);
    run_txn(4'b1010, 4'b1010, 4'b0101, 4'b1010, 1'b0, 8'd0, 1'b1, 4'b0110);
    run_txn(4'b0110, 4'b0100, 4'b1000, 4'b0110, 1'b0, 8'd0, 1'b0, 4'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
